// File: rtl/ins_encoder_writer.sv
// Packs decoded instruction fields into a 32-bit word {op,v2,v1,v0} and writes it
// little-endian into byte-wide program memory, one byte per accepted write.
module ins_encoder_writer #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        op,
  input  logic [7:0]        v2,
  input  logic [7:0]        v1,
  input  logic [7:0]        v0,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic [15:0]       ins_count,
  output logic              wrapped
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(3);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_nxt;
  logic [WORD_W-1:0]   sr;
  logic [ADDR_W-1:0]   ptr;

  logic accept;
  logic byte_done;
  logic last_done;

  assign accept    = in_valid & in_ready;
  assign byte_done = (state == S_WRITE) & mem_ready;
  assign last_done = byte_done & (idx == LAST_IDX);
  assign mem_addr  = ptr;

  // State register: FSM state and byte index within the current word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic: advance on each completed byte, re-arm on overlapped accept
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_WRITE;
          idx_nxt   = '0;
        end
      end
      S_WRITE: begin
        if (mem_ready) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = accept ? S_WRITE : S_IDLE;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output logic: memory strobe/data from state; ready overlaps the last byte
  always_comb begin
    mem_we   = 1'b0;
    busy     = 1'b0;
    mem_data = '0;
    in_ready = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        busy     = 1'b1;
        mem_data = sr[BYTE_W-1:0];
        in_ready = rst_n & (idx == LAST_IDX) & mem_ready;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Shift register: load packed word on accept, shift out one byte per completed write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (accept) begin
      sr <= {op, v2, v1, v0};
    end else if (byte_done) begin
      sr <= {BYTE_W'(0), sr[WORD_W-1:BYTE_W]};
    end
  end

  // Write pointer and sticky wrap flag; loads only take effect while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= BASE_ADDR;
      wrapped <= 1'b0;
    end else if ((state == S_IDLE) && addr_load) begin
      ptr     <= addr_in;
      wrapped <= 1'b0;
    end else if (byte_done) begin
      ptr <= ptr + ADDR_W'(1);
      if (ptr == {ADDR_W{1'b1}}) begin
        wrapped <= 1'b1;
      end
    end
  end

  // Completed-instruction counter, free-running wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_count <= '0;
    end else if (last_done) begin
      ins_count <= ins_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ins_encoder_writer.sv
// Scoreboard bench for ins_encoder_writer: the driver predicts every byte write
// (address, data, wrap, end-of-instruction) at accept time; a negedge monitor
// pops and compares each memory write as the DUT presents it.
module tb_ins_encoder_writer;

  localparam int unsigned ADDR_W = 4;
  localparam logic [ADDR_W-1:0] BASE = 4'd3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        op, v2, v1, v0;
  logic              addr_load;
  logic [ADDR_W-1:0] addr_in;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ready;
  logic              busy;
  logic [15:0]       ins_count;
  logic              wrapped;

  ins_encoder_writer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .v2(v2), .v1(v1), .v0(v0),
    .addr_load(addr_load), .addr_in(addr_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .busy(busy), .ins_count(ins_count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              last;
    logic              wrap;
  } item_t;

  item_t             q[$];
  int                n_cmp = 0;
  int                n_fail = 0;
  int                pushed = 0;
  int                done = 0;
  logic [ADDR_W-1:0] mp;
  bit                clr_wrap_pend = 1'b0;
  bit                acc;
  logic [15:0]       exp_count = '0;
  bit                exp_wrapped = 1'b0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Monitor: reset values, status outputs, and every presented memory write
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_mem_we", 32'(mem_we), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr), 32'(BASE));
      chk("rst_mem_data", 32'(mem_data), 32'(0));
      chk("rst_ins_count", 32'(ins_count), 32'(0));
      chk("rst_wrapped", 32'(wrapped), 32'(0));
      q.delete();
      done        = 0;
      exp_count   = '0;
      exp_wrapped = 1'b0;
    end else begin
      chk("ins_count", 32'(ins_count), 32'(exp_count));
      chk("wrapped", 32'(wrapped), 32'(exp_wrapped));
      chk("busy_vs_we", 32'(busy), 32'(mem_we));
      if (clr_wrap_pend) begin
        exp_wrapped   = 1'b0;
        clr_wrap_pend = 1'b0;
      end
      if (mem_we) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_data);
        end else begin
          chk("wr_addr", 32'(mem_addr), 32'(q[0].addr));
          chk("wr_data", 32'(mem_data), 32'(q[0].data));
          if (mem_ready) begin
            item_t it;
            it = q.pop_front();
            done++;
            if (it.wrap) exp_wrapped = 1'b1;
            if (it.last) exp_count = exp_count + 16'd1;
          end
        end
      end else begin
        chk("idle_data", 32'(mem_data), 32'(0));
      end
    end
  end

  // One clock of stimulus; predicts in_ready and, on accept, the four byte writes
  task automatic step(input logic iv, input logic [31:0] w, input logic mr,
                      input logic al, input logic [ADDR_W-1:0] ai);
    int   outst;
    logic er;
    item_t it;
    @(posedge clk);
    #1;
    in_valid  = iv;
    op        = w[31:24];
    v2        = w[23:16];
    v1        = w[15:8];
    v0        = w[7:0];
    mem_ready = mr;
    addr_load = al;
    addr_in   = ai;
    outst = pushed - done;
    er = (outst == 0) || (outst == 1 && mr);
    if (al && outst == 0) begin
      mp = ai;
      clr_wrap_pend = 1'b1;
    end
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(er));
    acc = iv && er;
    if (acc) begin
      for (int k = 0; k < 4; k++) begin
        it.addr = mp;
        it.data = 8'(w >> (8 * k));
        it.last = (k == 3);
        it.wrap = (mp == {ADDR_W{1'b1}});
        q.push_back(it);
        mp = mp + ADDR_W'(1);
      end
      pushed += 4;
    end
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b1, 1'b0, '0);
  endtask

  // Hold fields valid until accepted, with random backpressure and load attempts
  task automatic send(input logic [31:0] w, input int mr_pct, input int ld_pct);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      step(1'b1, w, 1'($urandom_range(99) < mr_pct), 1'($urandom_range(99) < ld_pct),
           ADDR_W'($urandom));
      ok = acc;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: word 0x%08h not accepted within 200 cycles", w);
    end
  endtask

  // Run until every predicted byte is written, then one idle cycle
  task automatic drain(input int mr_pct);
    for (int t = 0; t < 400 && pushed != done; t++) begin
      step(1'b0, 32'h0, 1'($urandom_range(99) < mr_pct), 1'b0, '0);
    end
    idle();
    chk("drain_outstanding", 32'(pushed - done), 32'(0));
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    addr_load = 1'b0;
    pushed = 0;
    mp = BASE;
    clr_wrap_pend = 1'b0;
    #1;
    chk("rst_async_we", 32'(mem_we), 32'(0));
    chk("rst_async_busy", 32'(busy), 32'(0));
    chk("rst_async_addr", 32'(mem_addr), 32'(BASE));
    chk("rst_async_ready", 32'(in_ready), 32'(0));
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    {op, v2, v1, v0} = 32'h0;
    addr_load = 1'b0;
    addr_in = '0;
    mem_ready = 1'b0;
    mp = BASE;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write at address 0
    step(1'b1, 32'h12345678, 1'b1, 1'b1, 4'd0);
    drain(100);
    chk("t1_count", 32'(ins_count), 32'(1));
    chk("t1_busy", 32'(busy), 32'(0));

    // Backpressure on byte 1
    step(1'b1, 32'h12345678, 1'b1, 1'b1, 4'd0);
    idle();
    repeat (3) step(1'b0, 32'h0, 1'b0, 1'b0, '0);
    drain(100);
    chk("t2_count", 32'(ins_count), 32'(2));

    // Back-to-back with fields held valid
    step(1'b1, 32'hA1B2C3D4, 1'b1, 1'b1, 4'd0);
    send(32'h55667788, 100, 0);
    drain(100);
    chk("t3_count", 32'(ins_count), 32'(4));

    // Wrap past top of address space, then cleared by a load
    step(1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 4'd14);
    drain(100);
    chk("t4_wrapped", 32'(wrapped), 32'(1));
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'd5);
    idle();
    chk("t4_cleared", 32'(wrapped), 32'(0));

    // Load ignored mid-write; load with accept lands at the loaded address
    step(1'b1, 32'h01020304, 1'b1, 1'b1, 4'd0);
    step(1'b0, 32'h0, 1'b1, 1'b1, 4'd9);
    drain(100);
    step(1'b1, 32'hF1E2D3C4, 1'b1, 1'b1, 4'd9);
    drain(100);

    // Reset after byte 1 of an instruction
    step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 4'd0);
    idle();
    idle();
    apply_reset();
    drain(100);
    idle();
    chk("t5_count", 32'(ins_count), 32'(0));

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      int gap;
      gap = int'($urandom_range(2));
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 32'h0, 1'($urandom_range(99) < 70), 1'($urandom_range(99) < 10),
             ADDR_W'($urandom));
      end
      send($urandom, 70, 10);
    end
    drain(70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
